acs_butterfly: RTL

Radix-2 add-compare-select butterfly for the rate-1/2 hard-decision Viterbi decoder. Sits directly downstream of the 2-bit branch metric units: takes the path metrics of predecessor states 2j and 2j+1 plus four 2-bit branch metrics, and produces the new path metrics of successor states j and j+32 with their survivor decision bits. It is a two-stage pipeline (add, then compare/select). Decisions feed the survivor memory; new metrics are written back to the path-metric bank by the surrounding array.

---
 rtl/viterbi_pkg.sv | 12 +
 rtl/acs_node.sv | 62 ++++++
 rtl/acs_butterfly.sv | 96 +++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder constants: default metric widths, trellis size and
// the normalization offset for the default path-metric width.
package viterbi_pkg;

    localparam int DEF_PM_W    = 8;
    localparam int DEF_BM_W    = 2;
    localparam int NUM_STATES  = 64;
    localparam int NORM_OFFSET = 1 << (DEF_PM_W - 1);

    typedef logic [DEF_PM_W-1:0] pm_t;

endpackage

// File: rtl/acs_node.sv
// One successor state of the ACS butterfly: saturating add of both candidate
// paths (stage 1), then min-select with survivor decision (stage 2).
module acs_node
    import viterbi_pkg::*;
#(
    parameter int PM_W = DEF_PM_W,
    parameter int BM_W = DEF_BM_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load_s1,
    input  logic            i_load_s2,
    input  logic [PM_W-1:0] i_pm_a,
    input  logic [PM_W-1:0] i_pm_b,
    input  logic [BM_W-1:0] i_bm_a,
    input  logic [BM_W-1:0] i_bm_b,
    output logic [PM_W-1:0] o_pm,
    output logic            o_dec
);

    logic [PM_W:0]   w_sum_a;
    logic [PM_W:0]   w_sum_b;
    logic [PM_W-1:0] w_sat_a;
    logic [PM_W-1:0] w_sat_b;
    logic            w_b_less;

    logic [PM_W-1:0] r_s_a;
    logic [PM_W-1:0] r_s_b;
    logic [PM_W-1:0] r_pm;
    logic            r_dec;

    // Extra carry bit detects overflow; clamp to all-ones so metrics never wrap.
    assign w_sum_a = {1'b0, i_pm_a} + (PM_W+1)'(i_bm_a);
    assign w_sum_b = {1'b0, i_pm_b} + (PM_W+1)'(i_bm_b);
    assign w_sat_a = w_sum_a[PM_W] ? '1 : w_sum_a[PM_W-1:0];
    assign w_sat_b = w_sum_b[PM_W] ? '1 : w_sum_b[PM_W-1:0];

    // Strict compare: a tie keeps the path from predecessor a.
    assign w_b_less = (r_s_b < r_s_a);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_a <= '0;
            r_s_b <= '0;
            r_pm  <= '0;
            r_dec <= 1'b0;
        end else begin
            if (i_load_s1) begin
                r_s_a <= w_sat_a;
                r_s_b <= w_sat_b;
            end
            if (i_load_s2) begin
                r_pm  <= w_b_less ? r_s_b : r_s_a;
                r_dec <= w_b_less;
            end
        end
    end

    assign o_pm  = r_pm;
    assign o_dec = r_dec;

endmodule

// File: rtl/acs_butterfly.sv
// Radix-2 ACS butterfly, two-stage pipeline (add, compare/select).
// Optional metric normalization is compiled in with `define ACS_NORM_EN.
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int PM_W = DEF_PM_W,
    parameter int BM_W = DEF_BM_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [BM_W-1:0] bm_a0,
    input  logic [BM_W-1:0] bm_b0,
    input  logic [BM_W-1:0] bm_a1,
    input  logic [BM_W-1:0] bm_b1,
    input  logic            norm_in,
    output logic            out_valid,
    output logic [PM_W-1:0] pm_0,
    output logic [PM_W-1:0] pm_1,
    output logic            dec_0,
    output logic            dec_1,
    output logic            norm_req
);

    logic [PM_W-1:0] w_pm_a_n;
    logic [PM_W-1:0] w_pm_b_n;
    logic [BM_W-1:0] w_bm_a [2];
    logic [BM_W-1:0] w_bm_b [2];
    logic [PM_W-1:0] w_node_pm [2];
    logic            w_node_dec [2];

    logic r_valid_s1;
    logic r_valid_s2;

`ifdef ACS_NORM_EN
    localparam logic [PM_W-1:0] W_NORM_OFF = PM_W'(1) << (PM_W - 1);
    logic w_norm_act;

    // Subtract the offset, flooring at zero for metrics below it.
    assign w_norm_act = in_valid & norm_in;
    assign w_pm_a_n   = !w_norm_act ? pm_a : (pm_a[PM_W-1] ? pm_a - W_NORM_OFF : '0);
    assign w_pm_b_n   = !w_norm_act ? pm_b : (pm_b[PM_W-1] ? pm_b - W_NORM_OFF : '0);
`else
    logic w_unused_norm;

    assign w_unused_norm = norm_in;
    assign w_pm_a_n      = pm_a;
    assign w_pm_b_n      = pm_b;
`endif

    assign w_bm_a[0] = bm_a0;
    assign w_bm_b[0] = bm_b0;
    assign w_bm_a[1] = bm_a1;
    assign w_bm_b[1] = bm_b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_s1 <= 1'b0;
            r_valid_s2 <= 1'b0;
        end else begin
            r_valid_s1 <= in_valid;
            r_valid_s2 <= r_valid_s1;
        end
    end

    // Node 0 produces successor j, node 1 produces successor j+32.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_node
            acs_node #(
                .PM_W (PM_W),
                .BM_W (BM_W)
            ) u_node (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_load_s1 (in_valid),
                .i_load_s2 (r_valid_s1),
                .i_pm_a    (w_pm_a_n),
                .i_pm_b    (w_pm_b_n),
                .i_bm_a    (w_bm_a[gi]),
                .i_bm_b    (w_bm_b[gi]),
                .o_pm      (w_node_pm[gi]),
                .o_dec     (w_node_dec[gi])
            );
        end
    endgenerate

    assign out_valid = r_valid_s2;
    assign pm_0      = w_node_pm[0];
    assign pm_1      = w_node_pm[1];
    assign dec_0     = w_node_dec[0];
    assign dec_1     = w_node_dec[1];
    assign norm_req  = r_valid_s2 & (w_node_pm[0][PM_W-1] | w_node_pm[1][PM_W-1]);

endmodule
